// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8-subset core:
//   - opcode prefixes for every supported instruction
//   - ALU operation, ALU B-source and write-back source enums
//   - the decoded control bundle carried from decode to datapath
//   - the B.cond condition code that is honoured (LT)
// ---------------------------------------------------------------------------
package legv8_pkg;

  // R/D-format and BR opcodes live in instr[31:21]
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  // I-format opcode lives in instr[31:22]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;

  // B-format opcodes live in instr[31:26]
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

  // CB-format opcodes live in instr[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  // The only B.cond condition that can be taken
  localparam logic [4:0]  COND_LT  = 5'b01011;

  // Register index that is hardwired to zero, and the link register
  localparam logic [4:0]  XZR      = 5'd31;
  localparam logic [4:0]  X_LINK   = 5'd30;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_XOR    = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_IMM9  = 2'd1,
    SRC_IMM12 = 2'd2
  } alu_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } mem_to_reg_e;

  // Decoded control bundle; all-zero fields describe a NOP
  typedef struct packed {
    logic        reg2loc;    // read port 2 uses Rt instead of Rm
    alu_src_e    alu_src;
    alu_op_e     alu_op;
    mem_to_reg_e mem_to_reg;
    logic        reg_write;
    logic        mem_write;
    logic        flag_write;
    logic        is_shift;   // write back shifter output instead of ALU
    logic        byte_xfer;  // LDURB/STURB: 1-byte transfer
    logic        link;       // BL: destination is X30
    logic        uncond;     // B/BL
    logic        cbz;
    logic        bcond;
    logic        br;
  } ctrl_t;

  // Sign-extend a word offset and turn it into a byte offset
  function automatic logic [63:0] branch_offset(input logic [31:0] instr,
                                                input logic        is_b26);
    if (is_b26) begin
      branch_offset = {{36{instr[25]}}, instr[25:0], 2'b00};
    end else begin
      branch_offset = {{43{instr[23]}}, instr[23:5], 2'b00};
    end
  endfunction

endpackage

// File: rtl/legv8_cpu_core_if.sv
// ---------------------------------------------------------------------------
// legv8_cpu_core_if
// Memory-side bus of the core: instruction fetch, data access and the
// architectural flags.
// Timing: there is no valid/ready handshake. Every cycle the core presents
// imem_addr and the data-side address/controls; the memories answer
// combinationally in the same cycle (imem_instr, dmem_rdata), and a store
// with dmem_we=1 is committed by the data memory on the rising clk edge.
//   core modport (master): drives imem_addr, dmem_addr, dmem_wdata, dmem_we,
//                          dmem_xfer_size, flags; samples imem_instr,
//                          dmem_rdata
//   mem  modport (slave) : the mirror image
// ---------------------------------------------------------------------------
interface legv8_cpu_core_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_xfer_size;
  logic [63:0] dmem_rdata;
  logic [3:0]  flags;

  modport core (
    output imem_addr,
    input  imem_instr,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_xfer_size,
    input  dmem_rdata,
    output flags
  );

  modport mem (
    input  imem_addr,
    output imem_instr,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_xfer_size,
    output dmem_rdata,
    input  flags
  );
endinterface

// File: rtl/legv8_regfile.sv
// ---------------------------------------------------------------------------
// legv8_regfile
// 32 x 64-bit register file, two asynchronous read ports, one write port
// that commits on the rising clock edge. X31 reads as zero and ignores
// writes. A read of a register being written in the same cycle returns the
// old contents.
//   clk_i, rst_ni        : clock, asynchronous active-low clear of all regs
//   ra1_i/rd1_o          : read port 1
//   ra2_i/rd2_o          : read port 2
//   we_i, wa_i, wd_i     : write port
// ---------------------------------------------------------------------------
module legv8_regfile
  import legv8_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [63:0] rd1_o,
  output logic [63:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [63:0] wd_i
);

  // Entry 31 exists only to keep indexing in range; it is never written.
  logic [63:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 64'd0;
      end
    end else if (we_i && (wa_i != XZR)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == XZR) ? 64'd0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == XZR) ? 64'd0 : regs_q[ra2_i];

endmodule

// File: rtl/legv8_cpu_core.sv
// ---------------------------------------------------------------------------
// legv8_cpu_core
// Single-cycle 64-bit LEGv8-subset core: one instruction retires per clock.
// Holds the PC, decode/control, register file, ALU, shifter and flags.
//   clk    : system clock, all state changes on the rising edge
//   reset  : asynchronous active-low reset (PC=RESET_PC, flags=0, regs=0)
//   bus    : memory-side interface (core modport), see legv8_cpu_core_if
// Parameter RESET_PC: PC value loaded while reset is low.
// ---------------------------------------------------------------------------
module legv8_cpu_core
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  legv8_cpu_core_if.core    bus
);

  logic [63:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;     // {N,Z,V,C}

  logic [31:0] instr;
  ctrl_t       ctrl;

  logic [4:0]  ra2, wa;
  logic [63:0] rd1, rd2;
  logic [63:0] wb_data;

  logic [63:0] alu_b, b_eff, alu_res, shift_res;
  logic [64:0] addsub;
  logic        alu_zero;
  logic        flag_n, flag_z, flag_v, flag_c;

  logic [63:0] pc_plus4, br_target;
  logic        lt_cond, taken;

  assign instr = bus.imem_instr;

  // ---------------- decode ----------------
  always_comb begin
    ctrl            = '0;
    ctrl.alu_src    = SRC_REG;
    ctrl.alu_op     = ALU_PASS_B;
    ctrl.mem_to_reg = WB_ALU;
    if (instr[31:22] == OP_ADDI) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_src   = SRC_IMM12;
      ctrl.alu_op    = ALU_ADD;
    end else if (instr[31:21] == OP_ADDS) begin
      ctrl.reg_write  = 1'b1;
      ctrl.flag_write = 1'b1;
      ctrl.alu_op     = ALU_ADD;
    end else if (instr[31:21] == OP_SUBS) begin
      ctrl.reg_write  = 1'b1;
      ctrl.flag_write = 1'b1;
      ctrl.alu_op     = ALU_SUB;
    end else if (instr[31:21] == OP_AND) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = ALU_AND;
    end else if (instr[31:21] == OP_EOR) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = ALU_XOR;
    end else if (instr[31:21] == OP_LSR) begin
      ctrl.reg_write = 1'b1;
      ctrl.is_shift  = 1'b1;
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_LDURB) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_src    = SRC_IMM9;
      ctrl.alu_op     = ALU_ADD;
      ctrl.mem_to_reg = WB_MEM;
      ctrl.byte_xfer  = (instr[31:21] == OP_LDURB);
    end else if (instr[31:21] == OP_STUR || instr[31:21] == OP_STURB) begin
      ctrl.reg2loc   = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.alu_src   = SRC_IMM9;
      ctrl.alu_op    = ALU_ADD;
      ctrl.byte_xfer = (instr[31:21] == OP_STURB);
    end else if (instr[31:21] == OP_BR) begin
      ctrl.br = 1'b1;
    end else if (instr[31:26] == OP_B) begin
      ctrl.uncond = 1'b1;
    end else if (instr[31:26] == OP_BL) begin
      ctrl.uncond     = 1'b1;
      ctrl.link       = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.mem_to_reg = WB_PC4;
    end else if (instr[31:24] == OP_CBZ) begin
      // Rt goes through the ALU unchanged so the zero detect sees it
      ctrl.reg2loc = 1'b1;
      ctrl.cbz     = 1'b1;
    end else if (instr[31:24] == OP_BCOND) begin
      ctrl.bcond = 1'b1;
    end
  end

  // ---------------- register file ----------------
  assign ra2 = ctrl.reg2loc ? instr[4:0] : instr[20:16];
  assign wa  = ctrl.link ? X_LINK : instr[4:0];

  legv8_regfile u_regfile (
    .clk_i  (clk),
    .rst_ni (reset),
    .ra1_i  (instr[9:5]),
    .ra2_i  (ra2),
    .rd1_o  (rd1),
    .rd2_o  (rd2),
    .we_i   (ctrl.reg_write),
    .wa_i   (wa),
    .wd_i   (wb_data)
  );

  // ---------------- ALU and shifter ----------------
  always_comb begin
    alu_b = rd2;
    case (ctrl.alu_src)
      SRC_IMM9:  alu_b = {{55{instr[20]}}, instr[20:12]};
      SRC_IMM12: alu_b = {52'd0, instr[21:10]};
      default:   alu_b = rd2;
    endcase
  end

  // Subtraction is A + ~B + 1 so bit 64 is the no-borrow carry.
  assign b_eff  = (ctrl.alu_op == ALU_SUB) ? ~alu_b : alu_b;
  assign addsub = {1'b0, rd1} + {1'b0, b_eff} + {64'd0, (ctrl.alu_op == ALU_SUB)};

  always_comb begin
    alu_res = alu_b;
    case (ctrl.alu_op)
      ALU_ADD, ALU_SUB: alu_res = addsub[63:0];
      ALU_AND:          alu_res = rd1 & alu_b;
      ALU_XOR:          alu_res = rd1 ^ alu_b;
      default:          alu_res = alu_b;
    endcase
  end

  assign shift_res = rd1 >> instr[15:10];
  assign alu_zero  = (alu_res == 64'd0);

  assign flag_n = alu_res[63];
  assign flag_z = alu_zero;
  assign flag_c = addsub[64];
  assign flag_v = (rd1[63] == b_eff[63]) && (addsub[63] != rd1[63]);

  // ---------------- write-back ----------------
  always_comb begin
    wb_data = ctrl.is_shift ? shift_res : alu_res;
    case (ctrl.mem_to_reg)
      WB_MEM:  wb_data = ctrl.byte_xfer ? {56'd0, bus.dmem_rdata[7:0]}
                                        : bus.dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = ctrl.is_shift ? shift_res : alu_res;
    endcase
  end

  // ---------------- next PC ----------------
  assign pc_plus4  = pc_q + 64'd4;
  assign br_target = pc_q + branch_offset(instr, ctrl.uncond);
  // B.LT looks at flags left by an earlier ADDS/SUBS, never the current one
  assign lt_cond   = (instr[4:0] == COND_LT) && (flags_q[3] != flags_q[1]);
  assign taken     = ctrl.uncond || (ctrl.cbz && alu_zero) || (ctrl.bcond && lt_cond);

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.br) begin
      pc_d = rd1;
    end else if (taken) begin
      pc_d = br_target;
    end
  end

  assign flags_d = ctrl.flag_write ? {flag_n, flag_z, flag_v, flag_c} : flags_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      flags_q <= 4'd0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // ---------------- bus outputs ----------------
  assign bus.imem_addr      = pc_q;
  assign bus.dmem_addr      = alu_res;
  assign bus.dmem_wdata     = rd2;
  assign bus.dmem_we        = ctrl.mem_write && reset;
  assign bus.dmem_xfer_size = ctrl.byte_xfer ? 4'd1 : 4'd8;
  assign bus.flags          = flags_q;

endmodule

// File: tb/tb_legv8_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_legv8_cpu_core
// Drives instructions and load data each cycle, predicts the visible
// behaviour with an architectural model (register array, PC, NZVC) and
// checks the core's bus outputs from a separate monitor process.
// ---------------------------------------------------------------------------
module tb_legv8_cpu_core;

  logic clk;
  logic reset;

  legv8_cpu_core_if bus ();

  legv8_cpu_core #(.RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  flags;
    logic        we;
    logic        mem;     // load or store: address is meaningful
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- reference model ----------------
  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  logic [3:0]  m_flags;   // {N,Z,V,C}

  function automatic logic [63:0] rreg(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_pc    = 64'h0;
    m_flags = 4'd0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one instruction for one cycle, queues the expected outputs and
  // advances the model past the clock edge.
  task automatic issue(input logic [31:0] ins, input logic [63:0] rdata);
    exp_t        e;
    logic [63:0] a, b, res, npc, wdata;
    logic [4:0]  rd;
    logic        wen, fen;
    logic [3:0]  nf;
    logic signed [64:0] s;
    logic [63:0] simm9, off26, off19;

    a     = rreg(ins[9:5]);
    simm9 = 64'($signed(ins[20:12]));
    off26 = 64'($signed(ins[25:0])) * 64'd4;
    off19 = 64'($signed(ins[23:5])) * 64'd4;
    npc   = m_pc + 64'd4;
    rd    = ins[4:0];
    wen   = 1'b0;
    fen   = 1'b0;
    wdata = 64'd0;
    nf    = m_flags;

    e       = '0;
    e.pc    = m_pc;
    e.flags = m_flags;
    e.size  = 4'd8;

    if (ins[31:22] == 10'b1001000100) begin            // ADDI
      wen = 1'b1; wdata = a + 64'(ins[21:10]);
    end else if (ins[31:21] == 11'b10101011000) begin   // ADDS
      b   = rreg(ins[20:16]);
      res = a + b;
      s   = $signed({a[63], a}) + $signed({b[63], b});
      nf  = {res[63], res == 64'd0, s[64] != s[63], res < a};
      wen = 1'b1; fen = 1'b1; wdata = res;
    end else if (ins[31:21] == 11'b11101011000) begin   // SUBS
      b   = rreg(ins[20:16]);
      res = a - b;
      s   = $signed({a[63], a}) - $signed({b[63], b});
      nf  = {res[63], res == 64'd0, s[64] != s[63], a >= b};
      wen = 1'b1; fen = 1'b1; wdata = res;
    end else if (ins[31:21] == 11'b10001010000) begin   // AND
      wen = 1'b1; wdata = a & rreg(ins[20:16]);
    end else if (ins[31:21] == 11'b11001010000) begin   // EOR
      wen = 1'b1; wdata = a ^ rreg(ins[20:16]);
    end else if (ins[31:21] == 11'b11010011010) begin   // LSR
      wen = 1'b1; wdata = a >> ins[15:10];
    end else if (ins[31:21] == 11'b11111000010) begin   // LDUR
      e.mem = 1'b1; e.addr = a + simm9;
      wen = 1'b1; wdata = rdata;
    end else if (ins[31:21] == 11'b00111000010) begin   // LDURB
      e.mem = 1'b1; e.addr = a + simm9; e.size = 4'd1;
      wen = 1'b1; wdata = {56'd0, rdata[7:0]};
    end else if (ins[31:21] == 11'b11111000000 || ins[31:21] == 11'b00111000000) begin
      e.mem = 1'b1; e.we = 1'b1; e.addr = a + simm9;  // STUR / STURB
      e.wdata = rreg(ins[4:0]);
      e.size  = (ins[31:21] == 11'b00111000000) ? 4'd1 : 4'd8;
    end else if (ins[31:21] == 11'b11010110000) begin   // BR
      npc = a;
    end else if (ins[31:26] == 6'b000101) begin         // B
      npc = m_pc + off26;
    end else if (ins[31:26] == 6'b100101) begin         // BL
      npc = m_pc + off26; wen = 1'b1; rd = 5'd30; wdata = m_pc + 64'd4;
    end else if (ins[31:24] == 8'b10110100) begin       // CBZ
      if (rreg(ins[4:0]) == 64'd0) npc = m_pc + off19;
    end else if (ins[31:24] == 8'b01010100) begin       // B.cond, only LT
      if (ins[4:0] == 5'b01011 && m_flags[3] != m_flags[1]) npc = m_pc + off19;
    end

    bus.imem_instr = ins;
    bus.dmem_rdata = rdata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (wen && rd != 5'd31) m_regs[rd] = wdata;
    if (fen) m_flags = nf;
    m_pc = npc;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [5:0] sh, input logic [4:0] rn,
                                        input logic [4:0] rd);
    return {op, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rn,
                                        input logic [4:0] rd);
    return {10'b1001000100, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                         input logic [4:0] rt);
    return {op, imm, rt};
  endfunction

  localparam logic [10:0] T_ADDS  = 11'b10101011000;
  localparam logic [10:0] T_SUBS  = 11'b11101011000;
  localparam logic [10:0] T_AND   = 11'b10001010000;
  localparam logic [10:0] T_EOR   = 11'b11001010000;
  localparam logic [10:0] T_LSR   = 11'b11010011010;
  localparam logic [10:0] T_LDUR  = 11'b11111000010;
  localparam logic [10:0] T_LDURB = 11'b00111000010;
  localparam logic [10:0] T_STUR  = 11'b11111000000;
  localparam logic [10:0] T_STURB = 11'b00111000000;
  localparam logic [10:0] T_BR    = 11'b11010110000;

  function automatic logic [31:0] rand_instr();
    logic [4:0] r1, r2, r3;
    r1 = 5'($urandom_range(0, 31));
    r2 = 5'($urandom_range(0, 31));
    r3 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 15))
      0:  return enc_i(12'($urandom()), r1, r2);
      1:  return enc_r(T_ADDS, r1, 6'($urandom()), r2, r3);
      2:  return enc_r(T_SUBS, r1, 6'($urandom()), r2, r3);
      3:  return enc_r(T_AND, r1, 6'($urandom()), r2, r3);
      4:  return enc_r(T_EOR, r1, 6'($urandom()), r2, r3);
      5:  return enc_r(T_LSR, r1, 6'($urandom()), r2, r3);
      6:  return enc_d(T_LDUR, 9'($urandom()), r1, r2);
      7:  return enc_d(T_LDURB, 9'($urandom()), r1, r2);
      8:  return enc_d(T_STUR, 9'($urandom()), r1, r2);
      9:  return enc_d(T_STURB, 9'($urandom()), r1, r2);
      10: return enc_r(T_BR, r1, 6'($urandom()), r2, r3);
      11: return enc_b(($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101, 26'($urandom()));
      12: return enc_cb(8'b10110100, 19'($urandom()), r1);
      13: return enc_cb(8'b01010100, 19'($urandom()),
                        ($urandom_range(0, 1) != 0) ? 5'b01011 : r1);
      14: return enc_d(T_STUR, 9'($urandom()), r1, r2);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_addr", bus.imem_addr, e.pc);
        check("flags", 64'(bus.flags), 64'(e.flags));
        check("dmem_we", 64'(bus.dmem_we), 64'(e.we));
        check("xfer_size", 64'(bus.dmem_xfer_size), 64'(e.size));
        if (e.mem) check("dmem_addr", bus.dmem_addr, e.addr);
        if (e.we)  check("dmem_wdata", bus.dmem_wdata, e.wdata);
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    reset          = 1'b0;
    bus.imem_instr = 32'h0;
    bus.dmem_rdata = 64'h0;
    model_reset();
    #2;
    check("reset_pc", bus.imem_addr, 64'h0);
    check("reset_flags", 64'(bus.flags), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // arithmetic, stores, conditional branches, byte load/store
    issue(enc_d(T_STUR, 9'd0, 5'd31, 5'd0), 64'h0);
    issue(enc_i(12'd5, 5'd31, 5'd1), 64'h0);
    issue(enc_i(12'd7, 5'd31, 5'd2), 64'h0);
    issue(enc_r(T_SUBS, 5'd2, 6'd0, 5'd1, 5'd3), 64'h0);
    issue(enc_d(T_STUR, 9'd8, 5'd31, 5'd3), 64'h0);
    issue(enc_cb(8'b01010100, 19'd3, 5'b01011), 64'h0);
    issue(enc_r(T_SUBS, 5'd1, 6'd0, 5'd2, 5'd3), 64'h0);
    issue(enc_cb(8'b01010100, 19'd3, 5'b01011), 64'h0);
    issue(enc_cb(8'b10110100, 19'h7FFFE, 5'd31), 64'h0);
    issue(enc_d(T_LDURB, 9'd0, 5'd31, 5'd4), 64'h1234_5678_9ABC_DEF0);
    issue(enc_d(T_STURB, 9'd3, 5'd31, 5'd4), 64'h0);
    issue(enc_d(T_STUR, 9'd0, 5'd31, 5'd3), 64'h0);

    // reset mid-run with a store on the bus
    bus.imem_instr = enc_d(T_STUR, 9'd0, 5'd31, 5'd3);
    reset = 1'b0;
    #1;
    check("async_reset_pc", bus.imem_addr, 64'h0);
    check("async_reset_flags", 64'(bus.flags), 64'h0);
    check("reset_we_forced", 64'(bus.dmem_we), 64'h0);
    @(posedge clk);
    #1;
    check("reset_held_pc", bus.imem_addr, 64'h0);
    reset = 1'b1;
    model_reset();

    issue(enc_d(T_STUR, 9'd0, 5'd31, 5'd3), 64'h0);   // X3 cleared by reset
    for (int i = 0; i < 7; i++) issue(32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(enc_b(6'b100101, 26'd4), 64'h0);            // BL at 0x20
    issue(enc_r(T_BR, 5'd0, 6'd0, 5'd30, 5'd0), 64'h0);

    // flag isolation
    issue(enc_i(12'd1, 5'd31, 5'd5), 64'h0);
    issue(enc_r(T_SUBS, 5'd5, 6'd0, 5'd31, 5'd6), 64'h0);
    issue(enc_r(T_LSR, 5'd0, 6'd1, 5'd6, 5'd7), 64'h0);
    issue(enc_r(T_ADDS, 5'd5, 6'd0, 5'd7, 5'd8), 64'h0);
    issue(enc_r(T_AND, 5'd5, 6'd0, 5'd7, 5'd9), 64'h0);
    issue(32'h0, 64'h0);
    issue(enc_d(T_STUR, 9'd16, 5'd31, 5'd8), 64'h0);
    issue(enc_d(T_STUR, 9'd24, 5'd31, 5'd9), 64'h0);
    issue(enc_r(T_EOR, 5'd9, 6'd0, 5'd8, 5'd31), 64'h0);
    issue(enc_d(T_STUR, 9'd0, 5'd31, 5'd31), 64'h0);

    // randomized stream
    for (int i = 0; i < 800; i++) begin
      issue(rand_instr(), {$urandom(), $urandom()});
    end
    for (int i = 0; i < 32; i++) begin
      issue(enc_d(T_STUR, 9'($urandom()), 5'($urandom_range(0, 31)), 5'(i)), 64'h0);
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/legv8_cpu_core.md
Name: legv8_cpu_core

Overview:
- Single-cycle 64-bit LEGv8-subset processor core. One instruction completes per clk cycle.
- Contains PC/next-PC logic, instruction decode/control, a 32x64 register file, ALU, shifter and the flag register.
- Instruction memory and data memory are external. The core drives their address/control and consumes combinational read data.
- Sits under the top-level CPU wrapper, which ties it to instruction and data memories.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  64  current PC.
- imem_instr  input  32  instruction at imem_addr, combinational.
- dmem_addr  output  64  ALU result (Rn + SignExt(imm9)).
- dmem_wdata  output  64  Rt register value.
- dmem_we  output  1  store strobe; memory writes on the clk rising edge.
- dmem_xfer_size  output  4  byte count: 8 for LDUR/STUR, 1 for LDURB/STURB, else 8.
- dmem_rdata  input  64  combinational read data.
- flags  output  4  registered {N,Z,V,C}.

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC, flags=0, all registers=0.
  - dmem_we is forced to 0 while reset is low.
- X31 always reads 0; writes to X31 are discarded.
- Decode, by opcode prefix:
  - ADDI 1001000100: Rd=Rn+ZeroExt(imm12).
  - ADDS 10101011000, SUBS 11101011000: Rd=Rn±Rm; flags update.
  - AND 10001010000, EOR 11001010000: Rd=Rn op Rm; flags unchanged.
  - LSR 11010011010: Rd=Rn>>shamt[15:10].
  - LDUR 11111000010: Rd=dmem_rdata.
  - LDURB 00111000010: Rd=ZeroExt(dmem_rdata[7:0]).
  - STUR 11111000000, STURB 00111000000: dmem_we=1.
  - B 000101, BL 100101 (BL: X30=PC+4).
  - CBZ 10110100.
  - B.cond 01010100, taken only when cond field [4:0]=01011 (LT).
  - BR 11010110000: PC=Rn.
  - Any other encoding: NOP (no register/memory/flag write, PC+4).
- Control signals:
  - Reg2Loc selects Rm [20:16] vs Rt [4:0] as read port 2. Rt is used for STUR, STURB and CBZ.
  - ALUSrc: 0=reg, 1=SignExt(imm9 [20:12]), 2=ZeroExt(imm12 [21:10]).
  - ALUOp: 000 pass-B, 010 add, 011 sub, 100 and, 110 xor.
  - MemToReg: 0=ALU/shifter, 1=memory, 2=PC+4.
- Flags:
  - Z = result==0.
  - N = result[63].
  - V = signed overflow of the add/sub.
  - C = carry-out. For SUBS, C = no-borrow (A+~B+1 carry).
  - Flags are latched only by ADDS/SUBS at the clk edge.
- Branches:
  - Branch target = PC + (SignExt(imm)<<2). imm26 = [25:0] for B/BL; imm19 = [23:5] for CBZ/B.cond.
  - B.LT is taken iff registered N != registered V, i.e. flags from a prior instruction, not the current one.
  - CBZ is taken iff Rt==0 (combinational ALU zero on pass-B).
  - Not taken: PC=PC+4.
- A register read in the same cycle it is written returns the old value. The write lands at the edge.
- All arithmetic is 64-bit modulo 2^64.

Decomposition:
- Package legv8_pkg holds:
  - opcode constants;
  - ALUOp, ALUSrc and MemToReg enums;
  - the cond code LT.
- One natural sub-module: legv8_regfile (32x64, two async read ports, one sync write, X31 hardwired zero).
- Decode and ALU stay inline.

Test Plan:
- Reset: hold reset=0 mid-run.
  - imem_addr=0 immediately (asynchronously).
  - flags=0.
  - After release, STUR X0,[X31,#0] drives dmem_wdata=0.
- Arithmetic:
  - ADDI X1,X31,#5; ADDI X2,X31,#7; SUBS X3,X1,X2 -> flags N=1,Z=0,V=0,C=0.
  - STUR X3,[X31,#8] -> dmem_addr=8, dmem_wdata=64'hFFFF_FFFF_FFFF_FFFE, dmem_we=1, xfer_size=8.
- Conditional branches:
  - After the SUBS above, B.LT +3 -> next imem_addr=PC+12.
  - After SUBS X3,X2,X1 (result 2, flags N=0,V=0), B.LT -> PC+4.
  - CBZ X31,-2 -> PC-8.
- Byte load/store:
  - dmem_rdata=64'h1234_5678_9ABC_DEF0 on LDURB X4,[X31,#0] -> X4=0xF0.
  - STURB X4,[X31,#3] -> dmem_addr=3, xfer_size=1.
- Link and return:
  - BL +4 at PC=0x20 -> X30=0x24, PC=0x30.
  - BR X30 -> PC=0x24.
- Flag isolation:
  - ADDS with 64'h7FFF..F + 1 -> V=1, N=1.
  - A following AND leaves flags unchanged.
  - Undefined encoding 32'h0 -> PC+4, no writes.
